// File: rtl/pid_pwm_driver.sv
// Edge-aligned PWM driver fed by the 16-bit pid controller output.
// The duty command is clamped to PERIOD and double-buffered through a shadow register,
// so a new duty is applied only at a period boundary.
// Optional complementary drive with dead-time: define PWM_DEADTIME_EN.
module pid_pwm_driver #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned PERIOD = 200,
    parameter int unsigned DEAD   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] duty_in,
    input  logic              duty_valid,
    output logic              pwm_out,
    output logic              pwm_n,
    output logic              period_start,
    output logic [CNT_W-1:0]  duty_active,
    output logic              sat
);

    localparam logic [CNT_W-1:0]  CntLast  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  CntPer   = CNT_W'(PERIOD);
    localparam logic [DATA_W-1:0] DataPer  = DATA_W'(PERIOD);

    // Reject illegal configurations at elaboration time.
    if (PERIOD < 2 || PERIOD > (2 ** CNT_W) - 1) begin : g_bad_period
        $error("pid_pwm_driver: PERIOD out of range");
    end
    if (DEAD < 1 || DEAD > PERIOD / 4) begin : g_bad_dead
        $error("pid_pwm_driver: DEAD out of range");
    end

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] shadow;
    logic             sat_pend;
    logic [CNT_W-1:0] clamped;
    logic             clamp_sat;
    logic             raw_pwm;

    // Clamp the duty command to the period; any excess (incl. upper bits) flags saturation.
    always_comb begin
        clamped   = duty_in[CNT_W-1:0];
        clamp_sat = 1'b0;
        if (duty_in > DataPer) begin
            clamped   = CntPer;
            clamp_sat = 1'b1;
        end
    end

    assign raw_pwm = (cnt < duty_active);

    // Free-running period counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == CntLast) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow register: last write in a period wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow   <= '0;
            sat_pend <= 1'b0;
        end else if (duty_valid) begin
            shadow   <= clamped;
            sat_pend <= clamp_sat;
        end
    end

    // Apply the buffered duty at the wrap; a write on that same edge goes straight through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_active <= '0;
            sat         <= 1'b0;
        end else if (cnt == CntLast) begin
            duty_active <= duty_valid ? clamped : shadow;
            sat         <= duty_valid ? clamp_sat : sat_pend;
        end
    end

    // Period marker, aligned with the registered pwm output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_start <= 1'b0;
        end else begin
            period_start <= (cnt == '0);
        end
    end

`ifdef PWM_DEADTIME_EN
    logic             raw_q;
    logic [CNT_W-1:0] run_q;
    logic [CNT_W-1:0] run_d;

    // Length of the current raw run including this cycle, saturating at DEAD+1.
    always_comb begin
        run_d = CNT_W'(1);
        if (raw_pwm == raw_q) begin
            run_d = (run_q > CNT_W'(DEAD)) ? run_q : run_q + 1'b1;
        end
    end

    // Each side is enabled only once its raw level has persisted longer than DEAD cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raw_q   <= 1'b0;
            run_q   <= '0;
            pwm_out <= 1'b0;
            pwm_n   <= 1'b0;
        end else begin
            raw_q   <= raw_pwm;
            run_q   <= run_d;
            pwm_out <= raw_pwm & (run_d > CNT_W'(DEAD));
            pwm_n   <= ~raw_pwm & (run_d > CNT_W'(DEAD));
        end
    end
`else
    // Plain registered compare output; low side unused.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= raw_pwm;
        end
    end

    assign pwm_n = 1'b0;
`endif

endmodule

// File: tb/tb_pid_pwm_driver.sv
// Scoreboard bench for pid_pwm_driver: stimulus pushes expected per-cycle outputs,
// a monitor pops and compares one cycle later.
module tb_pid_pwm_driver;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned PERIOD = 200;
    localparam int unsigned DEAD   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] duty_in;
    logic              duty_valid;
    logic              pwm_out;
    logic              pwm_n;
    logic              period_start;
    logic [CNT_W-1:0]  duty_active;
    logic              sat;

    pid_pwm_driver #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W),
        .PERIOD(PERIOD),
        .DEAD  (DEAD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .pwm_out     (pwm_out),
        .pwm_n       (pwm_n),
        .period_start(period_start),
        .duty_active (duty_active),
        .sat         (sat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pwm;
        logic       pwm_n;
        logic       ps;
        logic [7:0] act;
        logic       sat;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   errors  = 0;

    // Reference model state: position in period, applied and pending duty.
    int m_cnt, m_act, m_sat, m_pend, m_psat, m_prev, m_run;

    function automatic void model_reset();
        m_cnt  = 0;
        m_act  = 0;
        m_sat  = 0;
        m_pend = 0;
        m_psat = 0;
        m_prev = 0;
        m_run  = 0;
    endfunction

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of input and predict the outputs after the following clock edge.
    task automatic step(input bit v, input int d);
        exp_t e;
        int   raw, c, s;
        @(negedge clk);
        duty_valid = v;
        duty_in    = d[15:0];
        raw = (m_cnt < m_act) ? 1 : 0;
`ifdef PWM_DEADTIME_EN
        if (raw == m_prev) m_run = (m_run > int'(DEAD)) ? m_run : m_run + 1;
        else m_run = 1;
        m_prev  = raw;
        e.pwm   = (raw == 1) && (m_run > int'(DEAD));
        e.pwm_n = (raw == 0) && (m_run > int'(DEAD));
`else
        e.pwm   = (raw == 1);
        e.pwm_n = 1'b0;
`endif
        e.ps = (m_cnt == 0);
        c = (d > int'(PERIOD)) ? int'(PERIOD) : (d % 256);
        s = (d > int'(PERIOD)) ? 1 : 0;
        if (m_cnt == int'(PERIOD) - 1) begin
            m_act = v ? c : m_pend;
            m_sat = v ? s : m_psat;
        end
        if (v) begin
            m_pend = c;
            m_psat = s;
        end
        e.act = 8'(m_act);
        e.sat = (m_sat != 0);
        m_cnt = (m_cnt + 1) % int'(PERIOD);
        q.push_back(e);
    endtask

    task automatic run(input int n, input bit v, input int d);
        for (int i = 0; i < n; i++) step(v, d);
    endtask

    // Monitor: compare DUT outputs against the oldest prediction just after each edge.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {pwm_out, pwm_n, period_start, duty_active, sat};
                vectors++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle: got pwm=%b n=%b ps=%b act=%0d sat=%b expected pwm=%b n=%b ps=%b act=%0d sat=%b at %0t",
                             a.pwm, a.pwm_n, a.ps, a.act, a.sat,
                             e.pwm, e.pwm_n, e.ps, e.act, e.sat, $time);
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        duty_valid = 1'b0;
        duty_in    = '0;
        model_reset();
        #2;
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_pwm_n", int'(pwm_n), 0);
        check("reset_ps", int'(period_start), 0);
        check("reset_act", int'(duty_active), 0);
        check("reset_sat", int'(sat), 0);
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;

        // 165 held, then saturating 240, then 160
        run(400, 1'b1, 16'h00A5);
        step(1'b1, 16'h00F0);
        run(420, 1'b0, 0);
        step(1'b1, 16'h00A0);
        run(400, 1'b0, 0);
        // zero duty
        step(1'b1, 16'h0000);
        run(420, 1'b0, 0);
        // two writes in one period: last wins
        while (m_cnt != 10) step(1'b0, 0);
        step(1'b1, 16'h003C);
        run(30, 1'b0, 0);
        step(1'b1, 16'h006E);
        run(400, 1'b0, 0);
        // write-through on the wrap edge, shadow holding another value
        step(1'b1, 16'h001E);
        while (m_cnt != int'(PERIOD) - 1) step(1'b0, 0);
        step(1'b1, 16'h0050);
        run(210, 1'b0, 0);
        // large and over-range values including upper-bit garbage
        step(1'b1, 16'hFF05);
        run(210, 1'b0, 0);
        step(1'b1, 200);
        run(210, 1'b0, 0);

        // asynchronous reset in the high phase
        step(1'b1, 16'h00A5);
        run(400, 1'b0, 0);
        while (m_cnt != 50) step(1'b0, 0);
        @(posedge clk);
        #2;
        check("pre_reset_pwm_high", int'(pwm_out), 1);
        #1 reset = 1'b1;
        #1;
        check("async_pwm", int'(pwm_out), 0);
        check("async_act", int'(duty_active), 0);
        check("async_ps", int'(period_start), 0);
        check("async_sat", int'(sat), 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        model_reset();
        run(250, 1'b0, 0);

        // randomized duty commands at random moments
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                case ($urandom_range(0, 3))
                    0: step(1'b1, int'($urandom_range(0, 65535)));
                    1: step(1'b1, int'($urandom_range(190, 210)));
                    2: step(1'b1, int'($urandom_range(0, 3)));
                    default: step(1'b1, int'($urandom_range(0, 255)));
                endcase
            end else begin
                step(1'b0, int'($urandom_range(0, 65535)));
            end
        end

        @(posedge clk);
        #2;
        if (q.size() != 0) check("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
